test_hu_udiv_seq_22ns_14ns_22: RTL and testbench
================================================

Name: test_Hu_udiv_seq_22ns_14ns_22

Overview:
- Iterative unsigned restoring divider: the inverse of the 8ns x 14ns -> 22-bit DSP multiplier used in the Hu-moment datapath.
- Takes a 22-bit product-width dividend and a 14-bit divisor.
- Returns the 22-bit quotient, the 14-bit remainder, and an 8-bit saturated quotient that recovers the original 8-bit multiplicand operand.
- Used for moment normalisation (central moment / area terms). Valid/ready handshake plus HLS-style ce.

Parameters:
- ID, 32'd1, instance id; no functional effect.
- DVD_WIDTH, 22, dividend and quotient width.
- DVS_WIDTH, 14, divisor and remainder width.
- SAT_WIDTH, 8, width of the saturated quotient output.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- ce  in  1  clock enable; when 0, all registers hold and no handshake completes.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- dividend  in  DVD_WIDTH  unsigned dividend.
- divisor  in  DVS_WIDTH  unsigned divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- quotient  out  DVD_WIDTH  unsigned quotient.
- remainder  out  DVS_WIDTH  unsigned remainder.
- quot_sat  out  SAT_WIDTH  quotient clamped to 2^SAT_WIDTH-1.
- quot_ovf  out  1  quotient > 2^SAT_WIDTH-1.
- div_by_zero  out  1  divisor was 0.

Behaviour:
- Reset (reset=0, async): state=IDLE; in_ready=1; out_valid=0; quotient, remainder, quot_sat, quot_ovf, div_by_zero all 0; iteration counter=0.
- FSM states: IDLE, BUSY, DONE. Every transition below requires ce=1 at the rising edge.
- IDLE: in_ready=1.
  - in_valid=1 and divisor!=0: latch operands; partial remainder R=0 (DVS_WIDTH+1 bits); counter=0; go BUSY.
  - in_valid=1 and divisor==0: quotient=all ones; remainder=dividend[DVS_WIDTH-1:0]; div_by_zero=1; quot_ovf=1; quot_sat=all ones; go DONE.
- BUSY: in_ready=0. One restoring step per ce edge:
  - T={R[DVS_WIDTH-1:0], dividend MSB}; shift dividend left.
  - If T>=divisor: R=T-divisor and shift 1 into the quotient LSB. Otherwise R=T and shift in 0.
  - When the step with counter==DVD_WIDTH-1 completes: go DONE; remainder=R[DVS_WIDTH-1:0]; compute quot_sat/quot_ovf from the final quotient; div_by_zero=0.
- DONE: out_valid=1; outputs stable until handshake. out_valid=1 and out_ready=1 with ce=1 -> IDLE, out_valid=0. No new operand is accepted in the same cycle; in_ready rises the cycle after.
- Latency: with divisor!=0, out_valid rises exactly DVD_WIDTH ce-cycles after the accept edge (22 for defaults). Divide-by-zero takes 1 cycle. Throughput is one operation per DVD_WIDTH+2 cycles, minimum.
- ce=0 in any state: FSM, counter, datapath and outputs are frozen. The handshake is ignored, even with in_valid/out_ready high.
- Arithmetic: quotient*divisor+remainder==dividend; remainder<divisor. quot_sat=quotient if quotient<=255, else 255.
- Outputs hold their last value in IDLE (not cleared) until the next result.
- reset asserted mid-BUSY or mid-DONE: immediate return to reset values. The in-flight operation is discarded; no out_valid is produced for it.

Test Plan:
1. dividend=1000000, divisor=300, out_ready=1 -> after 22 cycles: quotient=3333, remainder=100, quot_sat=255, quot_ovf=1, div_by_zero=0. in_ready low throughout BUSY.
2. dividend=4177665 (255*16383), divisor=16383 -> quotient=255, remainder=0, quot_sat=255, quot_ovf=0. Then dividend=4194303, divisor=1 -> quotient=4194303, remainder=0.
3. dividend=12345, divisor=0 -> next cycle out_valid=1: quotient=22'h3FFFFF, remainder=12345, div_by_zero=1, quot_ovf=1.
4. Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid and all results stable, in_ready=0. out_ready=1 -> IDLE next edge; in_ready=1 one cycle later.
5. ce toggled 0/1 every other cycle during scenario 1 -> identical results, out_valid after 22 ce-high edges. in_valid high with ce=0 is not accepted.
6. reset pulsed low at BUSY iteration 10 -> outputs zero immediately, in_ready=1 after release, no out_valid. A following 100/7 completes normally: quotient=14, remainder=2.

Source files
------------

// File: rtl/test_hu_udiv_seq_22ns_14ns_22.sv
// Iterative unsigned restoring divider: 22-bit dividend / 14-bit divisor, one
// quotient bit per enabled clock, with an 8-bit saturated quotient for operand recovery.
module test_hu_udiv_seq_22ns_14ns_22 #(
    parameter logic [31:0] ID        = 32'd1,
    parameter int          DVD_WIDTH = 22,
    parameter int          DVS_WIDTH = 14,
    parameter int          SAT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DVD_WIDTH-1:0] dividend,
    input  logic [DVS_WIDTH-1:0] divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DVD_WIDTH-1:0] quotient,
    output logic [DVS_WIDTH-1:0] remainder,
    output logic [SAT_WIDTH-1:0] quot_sat,
    output logic                 quot_ovf,
    output logic                 div_by_zero,
    output logic [1:0]           dbg_state,
    output logic [31:0]          dbg_id
);

    localparam int CW = $clog2(DVD_WIDTH);

    // Handshake: a transfer happens only on a rising edge with ce=1 and
    // valid=ready=1 on that side; with ce=0 nothing moves.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        count;
    logic [DVD_WIDTH-1:0] dvd_sh;
    logic [DVD_WIDTH-1:0] quo_sh;
    logic [DVS_WIDTH-1:0] dvs_q;
    logic [DVS_WIDTH:0]   rem_part;

    logic [DVS_WIDTH:0]   trial;
    logic                 fits;
    logic [DVS_WIDTH:0]   rem_next;
    logic [DVD_WIDTH-1:0] quo_next;
    logic                 ovf_next;
    logic [SAT_WIDTH-1:0] sat_next;
    logic                 last_step;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign dbg_state = state;
    assign dbg_id    = ID;

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    always_comb begin
        trial     = {rem_part[DVS_WIDTH-1:0], dvd_sh[DVD_WIDTH-1]};
        fits      = (trial >= {1'b0, dvs_q});
        rem_next  = fits ? (trial - {1'b0, dvs_q}) : trial;
        quo_next  = {quo_sh[DVD_WIDTH-2:0], fits};
        ovf_next  = |quo_next[DVD_WIDTH-1:SAT_WIDTH];
        sat_next  = ovf_next ? {SAT_WIDTH{1'b1}} : quo_next[SAT_WIDTH-1:0];
        last_step = (count == CW'(DVD_WIDTH - 1));
    end

    always_comb begin
        state_nxt = state;
        if (ce) begin
            case (state)
                IDLE: begin
                    if (in_valid) state_nxt = (divisor != '0) ? BUSY : DONE;
                end
                BUSY: begin
                    if (last_step) state_nxt = DONE;
                end
                DONE: begin
                    if (out_ready) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count       <= '0;
            dvd_sh      <= '0;
            quo_sh      <= '0;
            dvs_q       <= '0;
            rem_part    <= '0;
            quotient    <= '0;
            remainder   <= '0;
            quot_sat    <= '0;
            quot_ovf    <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (divisor != '0) begin
                            dvd_sh   <= dividend;
                            dvs_q    <= divisor;
                            quo_sh   <= '0;
                            rem_part <= '0;
                            count    <= '0;
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend[DVS_WIDTH-1:0];
                            quot_sat    <= '1;
                            quot_ovf    <= 1'b1;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    dvd_sh   <= {dvd_sh[DVD_WIDTH-2:0], 1'b0};
                    quo_sh   <= quo_next;
                    rem_part <= rem_next;
                    count    <= count + CW'(1);
                    if (last_step) begin
                        quotient    <= quo_next;
                        remainder   <= rem_next[DVS_WIDTH-1:0];
                        quot_sat    <= sat_next;
                        quot_ovf    <= ovf_next;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_test_hu_udiv_seq_22ns_14ns_22.sv
// Self-checking bench for the sequential 22/14 divider: directed scenarios
// plus randomized operations checked against an arithmetic reference model.
module tb_test_hu_udiv_seq_22ns_14ns_22;

    localparam int RW = 22 + 14 + 8 + 1 + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic        in_ready;
    logic [21:0] dividend;
    logic [13:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [21:0] quotient;
    logic [13:0] remainder;
    logic [7:0]  quot_sat;
    logic        quot_ovf;
    logic        div_by_zero;
    logic [1:0]  dbg_state;
    logic [31:0] dbg_id;

    logic [RW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    test_hu_udiv_seq_22ns_14ns_22 dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .quot_sat   (quot_sat),
        .quot_ovf   (quot_ovf),
        .div_by_zero(div_by_zero),
        .dbg_state  (dbg_state),
        .dbg_id     (dbg_id)
    );

    function automatic logic [RW-1:0] model(input int unsigned dvd, input int unsigned dvs);
        int unsigned q, r;
        logic [7:0]  sat;
        logic        ovf;
        if (dvs == 0) begin
            return {22'h3FFFFF, dvd[13:0], 8'hFF, 1'b1, 1'b1};
        end
        q   = dvd / dvs;
        r   = dvd % dvs;
        ovf = (q > 255);
        sat = ovf ? 8'd255 : q[7:0];
        return {q[21:0], r[13:0], sat, ovf, 1'b0};
    endfunction

    function automatic logic [RW-1:0] observed();
        return {quotient, remainder, quot_sat, quot_ovf, div_by_zero};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        ce        = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #3;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
        n_checks++;
        if (observed() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 0", observed());
        end
        step();
        step();
        reset = 1'b1;
        ce    = 1'b1;
        step();
    endtask

    // Runs one operation; toggle_ce alternates ce while waiting, hold keeps
    // out_ready low for that many cycles after the result appears.
    task automatic do_op(input int unsigned dvd, input int unsigned dvs,
                         input bit toggle_ce, input int hold, input string tag);
        logic [RW-1:0] exp, held;
        int n, cyc;
        bit busy_ok;
        exp = model(dvd, dvs);
        exp_q.push_back(exp);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle_ready: in_ready=%b, required 1", tag, in_ready);
        end
        dividend = dvd[21:0];
        divisor  = dvs[13:0];
        in_valid = 1'b1;
        out_ready = 1'b0;
        if (toggle_ce) begin
            ce = 1'b0;
            step();
            n_checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s ce0_accept: in_ready=%b out_valid=%b, required 1/0", tag, in_ready, out_valid);
            end
        end
        ce = 1'b1;
        step();
        in_valid = 1'b0;
        dividend = 22'($urandom);
        divisor  = 14'($urandom);
        n = 0;
        cyc = 0;
        busy_ok = 1'b1;
        while (out_valid !== 1'b1 && cyc < 200) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            ce = toggle_ce ? ~ce : 1'b1;
            if (toggle_ce) out_ready = 1'b1;
            step();
            if (ce) n++;
            cyc++;
        end
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timeout: out_valid=%b after %0d cycles, required 1", tag, out_valid, cyc);
        end
        n_checks++;
        if (!busy_ok) begin
            n_fail++;
            $display("FAIL %s busy_ready: in_ready seen 1 while busy, required 0", tag);
        end
        n_checks++;
        if (n != ((dvs == 0) ? 0 : 22)) begin
            n_fail++;
            $display("FAIL %s latency: %0d ce edges, required %0d", tag, n, (dvs == 0) ? 0 : 22);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (observed() !== exp) begin
            n_fail++;
            $display("FAIL %s result: got q=%0d r=%0d sat=%0d ovf=%b dz=%b, required q=%0d r=%0d sat=%0d ovf=%b dz=%b",
                     tag, quotient, remainder, quot_sat, quot_ovf, div_by_zero,
                     exp[45:24], exp[23:10], exp[9:2], exp[1], exp[0]);
        end
        held = observed();
        for (int i = 0; i < hold; i++) begin
            ce = 1'b1;
            step();
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || observed() !== held) begin
                n_fail++;
                $display("FAIL %s backpressure: out_valid=%b in_ready=%b res=%h, required 1/0/%h",
                         tag, out_valid, in_ready, observed(), held);
            end
        end
        if (toggle_ce) begin
            ce = 1'b0;
            out_ready = 1'b1;
            step();
            n_checks++;
            if (out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL %s ce0_consume: out_valid=%b, required 1", tag, out_valid);
            end
        end
        ce = 1'b1;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || observed() !== held) begin
            n_fail++;
            $display("FAIL %s consume: out_valid=%b in_ready=%b res=%h, required 0/1/%h",
                     tag, out_valid, in_ready, observed(), held);
        end
    endtask

    task automatic test_basic();
        do_op(1000000, 300, 1'b0, 0, "basic");
        do_op(4177665, 16383, 1'b0, 0, "sat_edge");
        do_op(4194303, 1, 1'b0, 0, "max_dvd");
    endtask

    task automatic test_div_zero();
        do_op(12345, 0, 1'b0, 0, "div_zero");
    endtask

    task automatic test_backpressure();
        do_op(1000000, 300, 1'b0, 5, "backpressure");
    endtask

    task automatic test_ce_toggle();
        do_op(1000000, 300, 1'b1, 2, "ce_toggle");
    endtask

    task automatic test_reset_mid_busy();
        bit seen;
        dividend = 22'd1000000;
        divisor  = 14'd300;
        in_valid = 1'b1;
        ce       = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || observed() !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: in_ready=%b out_valid=%b res=%h, required 1/0/0",
                     in_ready, out_valid, observed());
        end
        step();
        reset = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_discard: out_valid seen=%b in_ready=%b, required 0/1", seen, in_ready);
        end
        do_op(100, 7, 1'b0, 0, "after_reset");
    endtask

    task automatic test_random();
        int unsigned dvd, dvs;
        for (int i = 0; i < 16; i++) begin
            dvs = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 16383);
            dvd = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 4194303)
                                              : $urandom_range(0, 3000);
            do_op(dvd, dvs, 1'($urandom_range(0, 1)), $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_backpressure();
        test_ce_toggle();
        test_reset_mid_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
